// File: rtl/sa_result_reader.sv
// Result buffer for the systolic array: captures writeback results per entry and
// streams them to the host in address order over a valid/ready handshake.
module sa_result_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_we,
    input  logic [$clog2(DEPTH)-1:0]     wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         start,
    input  logic                         clr,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH)-1:0]     out_addr,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   valid_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [CW-1:0]       count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, done_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic accept, hit_valid, hit_bypass;

    assign accept     = out_valid_q & out_ready;
    assign hit_valid  = valid_q[ptr_q];
    assign hit_bypass = wb_we && (wb_addr == ptr_q);

    // NOTE: storage data is don't-care after reset, so the array has no reset and
    // lives in its own process; only the valid bits carry reset state.
    always_ff @(posedge clk) begin
        if (wb_we) mem_q[wb_addr] <= wb_data;
    end

    // clr wipes every valid bit first, then a same-cycle write re-marks its entry.
    always_comb begin
        valid_d = valid_q;
        if (clr)   valid_d = '0;
        if (wb_we) valid_d[wb_addr] = 1'b1;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
    end

    // NOTE: every signal gets its default before the case, so no path can leave a
    // value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        if (clr) begin
            state_d     = ST_IDLE;
            ptr_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_STREAM;
                        ptr_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (accept && out_last_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                    end else if (!out_valid_q || accept) begin
                        if (hit_valid || hit_bypass) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hit_valid ? mem_q[ptr_q] : wb_data;
                            out_addr_d  = ptr_q;
                            out_last_d  = (ptr_q == LAST_PTR);
                            ptr_d       = ptr_q + AW'(1);
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= (state_d == ST_STREAM);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign valid_count = count_q;

endmodule

// File: doc/sa_result_reader.md
SA_RESULT_READER -- requirements
Module: sa_result_reader

Interface
REQ-001: Parameter DATA_W, default 8, result element width in bits.
REQ-002: Parameter DEPTH, default 16, result entries (4x4 array outputs); address width 4.
REQ-003: clk  input  1  rising-edge clock.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: wb_we  input  1  writeback strobe from array writeback path.
REQ-006: wb_addr  input  4  writeback entry index.
REQ-007: wb_data  input  DATA_W  writeback result value (quantized, activated).
REQ-008: start  input  1  single-cycle pulse; begin streaming results from entry 0.
REQ-009: clr  input  1  single-cycle pulse; invalidate all entries, abort stream.
REQ-010: out_ready  input  1  host sink ready.
REQ-011: out_valid  output  1  out_data/out_addr/out_last hold a result.
REQ-012: out_data  output  DATA_W  result value.
REQ-013: out_addr  output  4  entry index of out_data.
REQ-014: out_last  output  1  high with entry DEPTH-1.
REQ-015: busy  output  1  high in STREAM.
REQ-016: done  output  1  high in DONE.
REQ-017: valid_count  output  5  number of entries with valid bit set (0..16).

Function
REQ-018: Storage SHALL be DEPTH x DATA_W registers plus one valid bit per entry.
REQ-019: wb_we SHALL write wb_data to entry wb_addr and set its valid bit at the clock edge, in every state.
REQ-020: Rewrite of an already-valid entry SHALL overwrite data; valid stays set; valid_count unchanged.
REQ-021: FSM states IDLE, STREAM, DONE; all outputs registered.
REQ-022: IDLE/DONE + start -> STREAM, read pointer ptr=0, out_valid=0.
REQ-023: start in STREAM SHALL be ignored.
REQ-024: In STREAM, output slot SHALL load entry ptr when slot empty or being accepted this cycle and entry ptr valid; ptr then increments.
REQ-025: Bypass: if entry ptr invalid but wb_we with wb_addr==ptr in same cycle, slot SHALL load wb_data at that edge (out_valid next cycle).
REQ-026: Entry ptr invalid and no bypass -> stall; out_valid falls after pending accept, ptr holds.
REQ-027: Transfer = out_valid & out_ready; full throughput one result per cycle while entries valid and out_ready high.
REQ-028: While out_valid=1 and out_ready=0, out_data/out_addr/out_last SHALL remain stable even if the entry is rewritten.
REQ-029: Transfer with out_last=1 -> DONE at that edge; out_valid=0; no further loads (no wrap-around).
REQ-030: DONE holds until start (re-stream from 0, data retained) or clr.
REQ-031: clr in any state -> IDLE, all valid bits cleared, out_valid=0, ptr=0 at that edge; storage data not cleared.
REQ-032: clr and wb_we same cycle: clr clears all valid bits, then the written entry's valid bit SHALL be set (write wins for that entry); no bypass load.
REQ-033: clr and start same cycle: clr wins; state IDLE.
REQ-034: valid_count SHALL reflect valid bits after each edge, including simultaneous clr+write (=1).

Reset
REQ-035: rst SHALL immediately force IDLE, ptr=0, all valid bits 0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, valid_count=0.
REQ-036: Storage data is don't-care after reset; rst mid-stream SHALL abort with no further out_valid until new start.

Verification
REQ-037: Write entries 0..15 with value 0x10+i, start, out_ready=1 -> 16 consecutive transfers 0x10..0x1F, out_addr 0..15, out_last only on 15, done next cycle.
REQ-038: start with no entries valid, then wb_we entry 0 = 0xA5 -> out_valid cycle after write, out_data 0xA5 (bypass), stall resumes at entry 1.
REQ-039: Full buffer, out_ready toggling 1,0,0,1 -> held data stable during 0s, no loss/duplication; overwrite of presented entry during hold does not change out_data.
REQ-040: clr together with wb_we entry 5 = 0x33 in STREAM -> IDLE, out_valid=0, valid_count=1; later start streams 0x33 only after entries 0..4 written.
REQ-041: rst asserted mid-stream after 7 transfers -> all outputs 0 asynchronously, valid_count=0; start after rst with empty buffer -> out_valid stays 0.
REQ-042: After DONE, start -> identical 16-entry sequence replayed without new writes.
